// File: rtl/tff_count_ctrl_pkg.sv
// tff_count_ctrl_pkg: state encoding shared by the T-FF bank controllers
package tff_count_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/tff_bank.sv
// tff_bank: WIDTH T flip-flops, each toggling when its t input is high
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);
    // every bit toggles on its own t; reset clears the whole bank
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= '0;
        else
            q <= q ^ t;
endmodule

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequences a T-FF bank as a programmable up/down counter
module tff_count_ctrl
    import tff_count_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] init,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] tog
);
    state_t           state;
    logic             dir_r;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] cnt_tog;
    logic             at_limit;

    assign at_limit = (q == limit_r);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .rst (rst),
        .t   (tog),
        .q   (q)
    );

    // ripple toggle: a bit flips when all lower bits are 1 (up) or all 0 (down)
    always_comb begin
        logic c;
        c       = 1'b1;
        cnt_tog = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_tog[i] = c;
            c          = c & (dir_r ? q[i] : ~q[i]);
        end
    end

    // toggle vector: load-by-toggle on start, count in RUN unless stopped or paused
    always_comb begin
        tog = '0;
        case (state)
            ST_RUN:  tog = (abort || at_limit || pause) ? '0 : cnt_tog;
            ST_DONE: tog = '0;
            default: tog = start ? (q ^ init) : '0;
        endcase
    end

    // control FSM with the direction and terminal value latched on an accepted start
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= ST_IDLE;
            dir_r   <= 1'b1;
            limit_r <= '0;
        end else begin
            case (state)
                ST_RUN:  state <= abort ? ST_IDLE : at_limit ? ST_DONE : ST_RUN;
                ST_DONE: state <= ST_IDLE;
                default: if (start) begin
                    state   <= ST_RUN;
                    dir_r   <= dir;
                    limit_r <= limit;
                end else
                    state <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: vector table, directed corner cases and randomized transactions
module tb_tff_count_ctrl;
    logic       clk = 0;
    logic       rst;
    logic       start, dir, pause, abort;
    logic [3:0] init, limit;
    logic       busy, done;
    logic [3:0] q, tog;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] m_q;

    tff_count_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .init  (init),
        .limit (limit),
        .pause (pause),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .tog   (tog)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic       start;
        logic       dir;
        logic [3:0] init;
        logic [3:0] limit;
        logic       pause;
        logic       abort;
        logic [3:0] eq;
        logic       eb;
        logic       ed;
        logic [3:0] et;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_q"}, q, m_q);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_tog"}, tog, 0);
    endtask

    // one transaction against a counting model: q moves by +/-1 mod 16 per unpaused RUN cycle
    task automatic run_txn(input logic [3:0] ti, input logic [3:0] tl, input logic td,
                           input logic [63:0] pm, input int ab, output int nrun);
        bit         ended, aborted;
        logic [3:0] nq;
        ended = 0; aborted = 0; nrun = 0;
        @(negedge clk);
        start = 1; dir = td; init = ti; limit = tl; pause = 1'($urandom); abort = 0;
        #1;
        chk("start_q", q, m_q);
        chk("start_tog", tog, m_q ^ ti);
        chk("start_busy", busy, 0);
        m_q = ti;
        for (int c = 0; c < 100 && !ended; c++) begin
            @(negedge clk);
            start = 1'($urandom); dir = 1'($urandom); init = 4'($urandom); limit = 4'($urandom);
            pause = (c < 64) ? pm[c] : 1'b0;
            abort = (c == ab);
            #1;
            nrun++;
            chk("run_q", q, m_q);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            if (c == ab) begin
                chk("abort_tog", tog, 0);
                aborted = 1; ended = 1;
            end else if (m_q == tl) begin
                chk("limit_tog", tog, 0);
                ended = 1;
            end else if (pause) begin
                chk("pause_tog", tog, 0);
            end else begin
                nq = td ? m_q + 4'd1 : m_q - 4'd1;
                chk("count_tog", tog, m_q ^ nq);
                m_q = nq;
            end
        end
        if (!ended) chk("run_timeout", 0, 1);
        if (!aborted) begin
            @(negedge clk);
            start = 1'($urandom); abort = 1'($urandom); pause = 1'($urandom);
            #1;
            chk("done_q", q, m_q);
            chk("done_done", done, 1);
            chk("done_busy", busy, 0);
            chk("done_tog", tog, 0);
        end
        @(negedge clk);
        start = 0; abort = 0; pause = 0;
        #1;
        idle_chk("after");
    endtask

    vec_t tbl[12];
    int   n;

    initial begin
        rst = 0; start = 0; dir = 0; init = 0; limit = 0; pause = 0; abort = 0;
        m_q = 0;
        repeat (2) @(negedge clk);
        #1;
        idle_chk("reset");
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            idle_chk("noop");
        end

        tbl[0]  = '{1, 1, 4'd3, 4'd7, 0, 0, 4'd0, 0, 0, 4'd3};
        tbl[1]  = '{0, 1, 4'd0, 4'd0, 0, 0, 4'd3, 1, 0, 4'd7};
        tbl[2]  = '{1, 0, 4'd0, 4'd4, 0, 0, 4'd4, 1, 0, 4'd1};
        tbl[3]  = '{1, 0, 4'd0, 4'd4, 0, 0, 4'd5, 1, 0, 4'd3};
        tbl[4]  = '{0, 0, 4'd0, 4'd0, 0, 0, 4'd6, 1, 0, 4'd1};
        tbl[5]  = '{0, 0, 4'd0, 4'd0, 0, 0, 4'd7, 1, 0, 4'd0};
        tbl[6]  = '{0, 0, 4'd0, 4'd0, 0, 0, 4'd7, 0, 1, 4'd0};
        tbl[7]  = '{0, 0, 4'd0, 4'd0, 0, 0, 4'd7, 0, 0, 4'd0};
        tbl[8]  = '{1, 1, 4'd9, 4'd9, 0, 0, 4'd7, 0, 0, 4'd14};
        tbl[9]  = '{1, 0, 4'd3, 4'd3, 1, 0, 4'd9, 1, 0, 4'd0};
        tbl[10] = '{1, 0, 4'd0, 4'd3, 0, 0, 4'd9, 0, 1, 4'd0};
        tbl[11] = '{0, 0, 4'd0, 4'd0, 0, 0, 4'd9, 0, 0, 4'd0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = tbl[i].start; dir = tbl[i].dir; init = tbl[i].init;
            limit = tbl[i].limit; pause = tbl[i].pause; abort = tbl[i].abort;
            #1;
            chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("vec%0d_done", i), done, tbl[i].ed);
            chk($sformatf("vec%0d_tog", i), tog, tbl[i].et);
        end
        m_q = 4'd9;

        run_txn(4'd3, 4'd7, 1'b1, 64'h1C, -1, n);
        chk("pause_run_cycles", n, 8);
        run_txn(4'd14, 4'd1, 1'b1, 64'h0, -1, n);
        chk("wrap_up_cycles", n, 4);
        run_txn(4'd1, 4'd14, 1'b0, 64'h0, -1, n);
        chk("wrap_down_cycles", n, 4);
        run_txn(4'd0, 4'd9, 1'b1, 64'h0, 4, n);
        chk("abort_q", q, 4);

        for (int k = 0; k < 25; k++)
            run_txn(4'($urandom), 4'($urandom), 1'($urandom),
                    {$urandom, $urandom} & {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1, n);

        @(negedge clk);
        start = 1; dir = 1; init = 4'd2; limit = 4'd12;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #2;
        chk("pre_rst_busy", busy, 1);
        rst = 0;
        #1;
        m_q = 0;
        idle_chk("async_rst");
        @(negedge clk);
        #1;
        idle_chk("held_rst");
        rst = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            idle_chk("post_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
